mix_columns_iter: RTL
=====================

// Module: mix_columns_iter
// PURPOSE
//  Sequential, parametrised MixColumns engine for the AES datapath. Accepts a
//  128-bit state over a valid/ready handshake and processes COLS_PER_CYCLE columns
//  per clock. Supports forward MixColumns and, optionally, InvMixColumns per
//  transaction. Sits between ShiftRows/InvShiftRows and AddRoundKey in the
//  iterative round loop; trades area against latency.
// PARAMETERS
//  COLS_PER_CYCLE  1  columns processed per clock; legal values are 1, 2 and 4; NCYC = 4/COLS_PER_CYCLE
//  INVERSE_EN      1  1 = InvMixColumns datapath is built; 0 = forward only, in_inverse ignored
// PORTS
//  clk         in   1    single clock; all state updates on the rising edge
//  rst         in   1    synchronous, active-high reset
//  in_valid    in   1    in_state/in_inverse are valid
//  in_ready    out  1    engine can accept a state (high only in IDLE)
//  in_state    in   128  input state; byte i = in_state[8i+:8]; column c = bytes 4c..4c+3, a0 = byte 4c
//  in_inverse  in   1    1 = apply InvMixColumns for this transaction (only when INVERSE_EN=1)
//  out_valid   out  1    out_state holds a finished result
//  out_ready   in   1    downstream accepts the result
//  out_state   out  128  result; same byte/column packing as in_state
//  busy        out  1    high in RUN or DONE
// BEHAVIOUR
//  - Reset values: out_valid=0, out_state=0, busy=0, in_ready=1, FSM=IDLE, col_idx=0.
//  - Reset takes effect on the clock edge where rst=1; it aborts any transaction in flight.
//    The partial result is discarded and no out_valid is produced for that transaction.
//  - FSM states: IDLE -> RUN -> DONE -> IDLE.
//    IDLE: in_ready=1. On in_valid&&in_ready, capture in_state into the work register,
//      latch the mode (in_inverse & INVERSE_EN), set col_idx=0, and go to RUN.
//    RUN: each cycle, columns col_idx .. col_idx+COLS_PER_CYCLE-1 are transformed in
//      place, then col_idx += COLS_PER_CYCLE. After NCYC cycles go to DONE; col_idx wraps to 0.
//    DONE: out_valid=1. out_state equals the work register and stays stable while
//      out_ready=0. On out_valid&&out_ready go to IDLE with out_valid=0 on the next cycle.
//  - Latency: with acceptance at edge T, out_valid is first high after edge T+NCYC
//    (4/2/1 cycles for COLS_PER_CYCLE = 1/2/4).
//  - Throughput: one state per NCYC+2 cycles with out_ready held high. No overlap:
//    in_ready=0 in RUN and DONE, and in_valid is ignored in those states.
//  - Forward column transform, GF(2^8) with modulus 0x11B:
//      b0=2a0^3a1^a2^a3   b1=a0^2a1^3a2^a3   b2=a0^a1^2a2^3a3   b3=3a0^a1^a2^2a3
//  - Inverse column transform: matrix rows {0E,0B,0D,09} rotated right by one per row.
//    Built as xtime chains (x2, x4, x8); no lookup tables.
//  - Mode is latched at acceptance. Changes on in_inverse during RUN or DONE have no effect.
//  - All products are 8 bits. xtime = {a[6:0],0} ^ (a[7] ? 8'h1B : 0). No width growth.
//  - Columns not yet processed in RUN keep their captured value. Only out_state is visible externally.
//  - Illegal COLS_PER_CYCLE: stop elaboration with a generate-time error.
// TESTING
//  1 Fwd, COLS=1: in_state={4{32'h455313db}}, in_inverse=0
//    -> out_valid 4 cycles after accept, out_state={4{32'hbca14d8e}}.
//  2 Inv, COLS=1: in_state={4{32'hbca14d8e}}, in_inverse=1 -> out_state={4{32'h455313db}}.
//  3 COLS=4, in_state={32'h455313db,32'hd5d4d4d4,32'h5c220af2,32'h01010101}
//    -> latency 1, out_state={32'hbca14d8e,32'hd6d7d5d5,32'h9d58dc9f,32'h01010101}.
//  4 Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_state stable,
//    out_valid=1, in_ready=0; in_valid pulses are ignored.
//  5 Reset mid-RUN: assert rst in 2nd RUN cycle -> next cycle out_valid=0,
//    busy=0, in_ready=1; a new transaction then completes correctly.
//  6 INVERSE_EN=0, COLS=2, in_inverse=1, in_state={4{32'h455313db}}
//    -> forward result {4{32'hbca14d8e}} after 2 cycles.

Source files
------------

// File: rtl/mix_columns_iter.sv
// Iterative AES MixColumns / InvMixColumns engine with valid/ready handshakes.
// Transforms COLS_PER_CYCLE columns per clock in place on a captured 128-bit state.
module mix_columns_iter #(
    parameter int COLS_PER_CYCLE = 1,
    parameter int INVERSE_EN     = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic         in_inverse,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);

    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
        $error("mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Step wraps to 0 for four columns per cycle, so col_idx stays at 0 there.
    localparam logic [1:0] COL_STEP = 2'(COLS_PER_CYCLE);
    localparam logic [1:0] LAST_IDX = 2'(4 - COLS_PER_CYCLE);
    localparam logic       INV_BIT  = (INVERSE_EN != 0) ? 1'b1 : 1'b0;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1B : 8'h00);
    endfunction

    // c[j][k] is byte j times the k-th coefficient of the first matrix row.
    function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv);
        logic [7:0]            a;
        logic [7:0]            x2;
        logic [7:0]            x4;
        logic [7:0]            x8;
        logic [3:0][3:0][7:0]  c;
        logic [3:0][7:0]       b;
        c = '0;
        b = '0;
        for (int j = 0; j < 4; j++) begin
            a  = col[8*j +: 8];
            x2 = xtime(a);
            x4 = xtime(x2);
            x8 = xtime(x4);
            if (inv) begin
                c[j] = {x8 ^ a, x8 ^ x4 ^ a, x8 ^ x2 ^ a, x8 ^ x4 ^ x2};
            end else begin
                c[j] = {a, a, x2 ^ a, x2};
            end
        end
        for (int r = 0; r < 4; r++) begin
            for (int j = 0; j < 4; j++) begin
                b[r] = b[r] ^ c[j][2'(j - r)];
            end
        end
        return b;
    endfunction

    state_t          state_q, state_d;
    logic [3:0][31:0] work_q, work_d;
    logic [1:0]      col_idx_q, col_idx_d;
    logic            inv_q, inv_d;
    logic [127:0]    out_state_q, out_state_d;
    logic            out_valid_q, out_valid_d;
    logic            in_ready_q, in_ready_d;
    logic            busy_q, busy_d;

    // Next-state and datapath logic for the capture / run / present sequence.
    always_comb begin
        state_d     = state_q;
        work_d      = work_q;
        col_idx_d   = col_idx_q;
        inv_d       = inv_q;
        out_state_d = out_state_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    state_d   = RUN;
                    work_d    = in_state;
                    inv_d     = in_inverse & INV_BIT;
                    col_idx_d = 2'd0;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                for (int k = 0; k < COLS_PER_CYCLE; k++) begin
                    work_d[col_idx_q + 2'(k)] = mix_col(work_q[col_idx_q + 2'(k)], inv_q);
                end
                col_idx_d = col_idx_q + COL_STEP;
                if (col_idx_q == LAST_IDX) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    out_state_d = work_d;
                end else begin
                    state_d = RUN;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d     = IDLE;
                col_idx_d   = 2'd0;
                out_valid_d = 1'b0;
            end
        endcase
        in_ready_d = (state_d == IDLE);
        busy_d     = (state_d != IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            work_q      <= '0;
            col_idx_q   <= 2'd0;
            inv_q       <= 1'b0;
            out_state_q <= 128'd0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            work_q      <= work_d;
            col_idx_q   <= col_idx_d;
            inv_q       <= inv_d;
            out_state_q <= out_state_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_state = out_state_q;
    assign busy      = busy_q;

endmodule
